// File: rtl/cpu_axi_pkg.sv
// Shared types for the AXI4-Lite load/store unit: access sizes, error codes,
// FSM states and AXI response encodings.
package cpu_axi_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_e;
  typedef enum logic [1:0] {ERR_OK, ERR_MISALIGN, ERR_BUSERR, ERR_TIMEOUT} lsu_err_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WR_XFER, ST_WR_RESP, ST_DONE
  } lsu_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // True when the address is not a multiple of the natural access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_e size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/cpu_axi_lsu_if.sv
// AXI4-Lite master port bundle used between the load/store unit and the bus.
interface cpu_axi_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lane_align.sv
// Byte-lane steering shared by loads and stores: store shift and strobes,
// load shift with sign/zero extension.
module axi_lane_align
  import cpu_axi_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [DATA_W-1:0] wdata_out,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata_out
);
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] keep_mask;
  logic [7:0]        byte_mask;
  logic              sign_bit;

  always_comb begin
    byte_mask = 8'hFF;
    keep_mask = '1;
    sign_bit  = 1'b0;
    rd_shift  = rdata_in >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin byte_mask = 8'h01; keep_mask = DATA_W'(8'hFF);         sign_bit = rd_shift[7];  end
      SZ_HALF: begin byte_mask = 8'h03; keep_mask = DATA_W'(16'hFFFF);      sign_bit = rd_shift[15]; end
      SZ_WORD: begin byte_mask = 8'h0F; keep_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = rd_shift[31]; end
      default: ;
    endcase
    wdata_out = wdata_in << {off, 3'b000};
    wstrb     = STRB_W'(byte_mask) << off;
    // Bits above the access width become copies of its top bit for signed loads.
    rdata_out = (rd_shift & keep_mask) | ((sign_bit & ~uns) ? ~keep_mask : '0);
  end
endmodule

// File: rtl/cpu_axi_lsu.sv
// AXI4-Lite load/store unit: one core access at a time, registered AXI
// outputs, single-cycle response with misalign / bus error / timeout codes.
module cpu_axi_lsu
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  cpu_axi_lsu_if.master     m_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  lsu_err_e          rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [OFF_W-1:0]  off_q, off_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, bready_q, bready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              idle, timed_out, bad_req;
  logic [OFF_W-1:0]  al_off;
  size_e             al_size;
  logic              al_uns;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic [STRB_W-1:0] al_wstrb;

  // In IDLE the aligner shapes the incoming store; afterwards it extends load data.
  assign idle    = (state_q == ST_IDLE);
  assign al_off  = idle ? req_addr[OFF_W-1:0] : off_q;
  assign al_size = idle ? size_e'(req_size) : size_q;
  assign al_uns  = idle ? req_unsigned : uns_q;

  axi_lane_align #(.DATA_W(DATA_W)) u_align (
    .off      (al_off),
    .size     (al_size),
    .uns      (al_uns),
    .wdata_in (req_wdata),
    .rdata_in (m_axi.rdata),
    .wdata_out(al_wdata),
    .wstrb    (al_wstrb),
    .rdata_out(al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    timed_out   = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    bad_req     = is_misaligned(req_addr[2:0], size_e'(req_size)) ||
                  ((DATA_W == 32) && (req_size == 2'd3));
    case (state_q)
      ST_IDLE: if (req_valid) begin
        off_d     = req_addr[OFF_W-1:0];
        size_d    = size_e'(req_size);
        uns_d     = req_unsigned;
        addr_d    = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        wdata_d   = al_wdata;
        wstrb_d   = al_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (bad_req) begin
          state_d     = ST_DONE;
          rsp_err_d   = ERR_MISALIGN;
          rsp_rdata_d = '0;
        end else begin
          state_d = req_we ? ST_WR_XFER : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (m_axi.arready) state_d = ST_RD_DATA;
                  else if (timed_out) begin
                    state_d = ST_DONE; rsp_err_d = ERR_TIMEOUT; rsp_rdata_d = '0;
                  end
      ST_RD_DATA: if (m_axi.rvalid) begin
                    state_d     = ST_DONE;
                    rsp_err_d   = (m_axi.rresp == AXI_OKAY) ? ERR_OK : ERR_BUSERR;
                    rsp_rdata_d = (m_axi.rresp == AXI_OKAY) ? al_rdata : '0;
                  end else if (timed_out) begin
                    state_d = ST_DONE; rsp_err_d = ERR_TIMEOUT; rsp_rdata_d = '0;
                  end
      ST_WR_XFER: begin
        aw_done_d = aw_done_q | (awvalid_q & m_axi.awready);
        w_done_d  = w_done_q  | (wvalid_q  & m_axi.wready);
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
        else if (timed_out) begin
          state_d = ST_DONE; rsp_err_d = ERR_TIMEOUT; rsp_rdata_d = '0;
        end
      end
      ST_WR_RESP: if (m_axi.bvalid) begin
                    state_d     = ST_DONE;
                    rsp_err_d   = (m_axi.bresp == AXI_OKAY) ? ERR_OK : ERR_BUSERR;
                    rsp_rdata_d = '0;
                  end else if (timed_out) begin
                    state_d = ST_DONE; rsp_err_d = ERR_TIMEOUT; rsp_rdata_d = '0;
                  end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (state_q inside {ST_RD_ADDR, ST_RD_DATA, ST_WR_XFER, ST_WR_RESP}) cnt_d = cnt_q + 1'b1;
    else cnt_d = '0;

    // Handshake outputs are decoded from the next state so they leave the flops clean.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    arvalid_d   = (state_d == ST_RD_ADDR);
    rready_d    = (state_d == ST_RD_DATA);
    awvalid_d   = (state_d == ST_WR_XFER) && !aw_done_d;
    wvalid_d    = (state_d == ST_WR_XFER) && !w_done_d;
    bready_d    = (state_d == ST_WR_RESP);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_cpu_axi_lsu.sv
// Directed bench for cpu_axi_lsu: a 32-bit unit (TIMEOUT=8) behind a
// programmable-delay slave and a 64-bit unit behind a zero-wait slave.
module tb_cpu_axi_lsu;
  import cpu_axi_pkg::*;

  logic        aclk = 1'b1;
  logic        rst  = 1'b1;
  logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
  logic        req_we = 1'b0, req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready32, req_ready64, rsp_valid32, rsp_valid64;
  logic [31:0] rsp_rdata32;
  logic [63:0] rsp_rdata64;
  logic [1:0]  rsp_err32, rsp_err64;

  cpu_axi_lsu_if #(.ADDR_W(32), .DATA_W(32)) a32 ();
  cpu_axi_lsu_if #(.ADDR_W(32), .DATA_W(64)) a64 ();

  cpu_axi_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u32 (
    .aclk(aclk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns),
    .req_wdata(req_wdata[31:0]), .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32),
    .rsp_err(rsp_err32), .m_axi(a32)
  );

  cpu_axi_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) u64 (
    .aclk(aclk), .rst(rst), .req_valid(req_valid64), .req_ready(req_ready64),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64),
    .rsp_err(rsp_err64), .m_axi(a64)
  );

  always #5 aclk = ~aclk;

  // Slave for the 32-bit unit: each ready/valid rises after a set number of waiting cycles.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] rdata32_v = '0;
  logic [1:0]  rresp32_v = AXI_OKAY, bresp32_v = AXI_OKAY;
  logic [63:0] rdata64_v = '0;

  always @(negedge aclk) begin
    a32.arready = a32.arvalid && (ar_cnt >= ar_dly);
    ar_cnt      = a32.arvalid ? ar_cnt + 1 : 0;
    a32.rvalid  = a32.rready && (r_cnt >= r_dly);
    r_cnt       = a32.rready ? r_cnt + 1 : 0;
    a32.awready = a32.awvalid && (aw_cnt >= aw_dly);
    aw_cnt      = a32.awvalid ? aw_cnt + 1 : 0;
    a32.wready  = a32.wvalid && (w_cnt >= w_dly);
    w_cnt       = a32.wvalid ? w_cnt + 1 : 0;
    a32.bvalid  = a32.bready && (b_cnt >= b_dly);
    b_cnt       = a32.bready ? b_cnt + 1 : 0;
    a32.rdata   = rdata32_v;
    a32.rresp   = rresp32_v;
    a32.bresp   = bresp32_v;
  end

  always @(negedge aclk) begin
    a64.arready = a64.arvalid;
    a64.rvalid  = a64.rready;
    a64.awready = a64.awvalid;
    a64.wready  = a64.wvalid;
    a64.bvalid  = a64.bready;
    a64.rdata   = rdata64_v;
    a64.rresp   = AXI_OKAY;
    a64.bresp   = AXI_OKAY;
  end

  // Bus monitor: beat counts, valid-high cycles and last transferred address/data.
  int arv32 = 0, ar32 = 0, awv32 = 0, aw32 = 0, wv32 = 0, w32 = 0, rsp32 = 0;
  logic [31:0] araddr32_seen = '0, awaddr32_seen = '0, wdata32_seen = '0;
  logic [3:0]  wstrb32_seen = '0;
  logic [31:0] araddr64_seen = '0, awaddr64_seen = '0;
  logic [63:0] wdata64_seen = '0;
  logic [7:0]  wstrb64_seen = '0;

  always @(posedge aclk) begin
    if (a32.arvalid) arv32++;
    if (a32.arvalid && a32.arready) begin ar32++; araddr32_seen = a32.araddr; end
    if (a32.awvalid) awv32++;
    if (a32.awvalid && a32.awready) begin aw32++; awaddr32_seen = a32.awaddr; end
    if (a32.wvalid) wv32++;
    if (a32.wvalid && a32.wready) begin
      w32++; wdata32_seen = a32.wdata; wstrb32_seen = a32.wstrb;
    end
    if (rsp_valid32) rsp32++;
    if (a64.arvalid && a64.arready) araddr64_seen = a64.araddr;
    if (a64.awvalid && a64.awready) awaddr64_seen = a64.awaddr;
    if (a64.wvalid && a64.wready) begin wdata64_seen = a64.wdata; wstrb64_seen = a64.wstrb; end
  end

  int n_checks = 0, n_pass = 0;
  int lat;
  logic [63:0] got_rdata;
  logic [1:0]  got_err;
  int s_arv, s_ar, s_awv, s_aw, s_wv, s_w, s_rsp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    s_arv = arv32; s_ar = ar32; s_awv = awv32; s_aw = aw32; s_wv = wv32; s_w = w32; s_rsp = rsp32;
  endtask

  // Issue one request, measure cycles from acceptance to rsp_valid, capture the response.
  task automatic do_req(input bit sel64, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wd);
    int guard;
    guard = 0;
    while (!(sel64 ? req_ready64 : req_ready32) && guard < 50) begin
      @(negedge aclk); guard++;
    end
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
    if (sel64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
    @(negedge aclk);
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    lat = 1;
    while (!(sel64 ? rsp_valid64 : rsp_valid32) && lat < 40) begin
      @(negedge aclk); lat++;
    end
    got_rdata = sel64 ? rsp_rdata64 : {32'h0, rsp_rdata32};
    got_err   = sel64 ? rsp_err64 : rsp_err32;
    $display("req sel64=%0d we=%0d addr=%08h size=%0d uns=%0d -> lat=%0d err=%0d rdata=%0h",
             sel64, we, addr, size, uns, lat, got_err, got_rdata);
    @(negedge aclk);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check("rst_req_ready", req_ready32, 1);
    check("rst_valids", {a32.arvalid, a32.awvalid, a32.wvalid, a32.rready, a32.bready, rsp_valid32}, 0);
    check("rst_addr_data", {a32.araddr, a32.wdata, a32.wstrb}, 0);
    check("rst_rsp", {rsp_err32, rsp_rdata32}, 0);
    rst = 1'b0;
    @(negedge aclk);

    rdata32_v = 32'h80FF_0000;
    do_req(0, 0, 32'h1000_0003, 2'd0, 0, 0);
    check("lb_araddr", araddr32_seen, 64'h1000_0000);
    check("lb_rdata", got_rdata, 64'hFFFF_FF80);
    check("lb_err", got_err, 0);
    check("lb_lat", lat, 3);
    do_req(0, 0, 32'h1000_0003, 2'd0, 1, 0);
    check("lbu_rdata", got_rdata, 64'h0000_0080);
    do_req(0, 0, 32'h1000_0002, 2'd1, 0, 0);
    check("lh_rdata", got_rdata, 64'hFFFF_80FF);

    r_dly = 2;
    do_req(0, 0, 32'h1000_0000, 2'd2, 0, 0);
    check("lw_wait2_lat", lat, 5);
    check("lw_wait2_rdata", got_rdata, 64'h80FF_0000);
    r_dly = 0;

    do_req(0, 1, 32'h1000_0002, 2'd1, 0, 64'h0000_BEEF);
    check("sh_awaddr", awaddr32_seen, 64'h1000_0000);
    check("sh_wdata", wdata32_seen, 64'hBEEF_0000);
    check("sh_wstrb", wstrb32_seen, 4'b1100);
    check("sh_lat", lat, 3);
    check("sh_rsp", {got_err, got_rdata}, 0);
    do_req(0, 1, 32'h1000_0001, 2'd0, 0, 64'h0000_00A5);
    check("sb_wdata", wdata32_seen, 64'h0000_A500);
    check("sb_wstrb", wstrb32_seen, 4'b0010);

    aw_dly = 3;
    snap();
    do_req(0, 1, 32'h1000_0004, 2'd2, 0, 64'hDEAD_BEEF);
    check("wfirst_aw_beats", aw32 - s_aw, 1);
    check("wfirst_w_beats", w32 - s_w, 1);
    check("wfirst_wvalid_cycles", wv32 - s_wv, 1);
    check("wfirst_awvalid_cycles", awv32 - s_awv, 4);
    check("wfirst_rsp_cycles", rsp32 - s_rsp, 1);
    check("wfirst_lat", lat, 6);
    check("wfirst_wdata", wdata32_seen, 64'hDEAD_BEEF);
    aw_dly = 0;

    snap();
    do_req(0, 0, 32'h1000_0002, 2'd2, 0, 0);
    check("mis_err", got_err, ERR_MISALIGN);
    check("mis_lat", lat, 1);
    check("mis_no_arvalid", arv32 - s_arv, 0);
    check("mis_rdata", got_rdata, 0);

    rdata32_v = 32'h1234_5678; rresp32_v = AXI_SLVERR;
    do_req(0, 0, 32'h1000_0008, 2'd2, 0, 0);
    check("slverr_err", got_err, ERR_BUSERR);
    check("slverr_rdata", got_rdata, 0);
    rresp32_v = AXI_OKAY;
    bresp32_v = AXI_DECERR;
    do_req(0, 1, 32'h1000_0010, 2'd2, 0, 64'h1);
    check("decerr_err", got_err, ERR_BUSERR);
    bresp32_v = AXI_OKAY;

    ar_dly = 1000;
    snap();
    do_req(0, 0, 32'h1000_000C, 2'd2, 0, 0);
    check("to_err", got_err, ERR_TIMEOUT);
    check("to_arvalid_cycles", arv32 - s_arv, 8);
    check("to_ar_beats", ar32 - s_ar, 0);
    check("to_lat", lat, 9);
    ar_dly = 0;

    snap();
    do_req(0, 1, 32'h1000_0008, 2'd3, 0, 64'h1);
    check("sd32_err", got_err, ERR_MISALIGN);
    check("sd32_no_aw", awv32 - s_awv, 0);

    // Reset while the read data phase is stalled.
    r_dly = 1000;
    snap();
    req_we = 0; req_addr = 32'h1000_0000; req_size = 2'd2; req_uns = 0; req_valid32 = 1'b1;
    @(negedge aclk);
    req_valid32 = 1'b0;
    @(negedge aclk);
    check("mid_rready_before", a32.rready, 1);
    rst = 1'b1;
    @(negedge aclk);
    rst = 1'b0;
    check("mid_rst_handshakes", {a32.rready, a32.arvalid, a32.awvalid, a32.wvalid, rsp_valid32}, 0);
    check("mid_rst_req_ready", req_ready32, 1);
    r_dly = 0;
    repeat (3) @(negedge aclk);
    check("mid_rst_no_rsp", rsp32 - s_rsp, 0);

    rdata64_v = 64'h1122_3344_5566_7788;
    do_req(1, 0, 32'h2000_0008, 2'd3, 0, 0);
    check("ld64_araddr", araddr64_seen, 64'h2000_0008);
    check("ld64_rdata", got_rdata, 64'h1122_3344_5566_7788);
    check("ld64_lat", lat, 3);
    rdata64_v = 64'h8000_0001_0000_0000;
    do_req(1, 0, 32'h2000_0004, 2'd2, 0, 0);
    check("lw64_araddr", araddr64_seen, 64'h2000_0000);
    check("lw64_rdata", got_rdata, 64'hFFFF_FFFF_8000_0001);
    do_req(1, 0, 32'h2000_0004, 2'd2, 1, 0);
    check("lwu64_rdata", got_rdata, 64'h0000_0000_8000_0001);
    do_req(1, 1, 32'h2000_000C, 2'd2, 0, 64'hCAFE_F00D);
    check("sw64_awaddr", awaddr64_seen, 64'h2000_0008);
    check("sw64_wdata", wdata64_seen, 64'hCAFE_F00D_0000_0000);
    check("sw64_wstrb", wstrb64_seen, 8'hF0);
    check("sw64_err", got_err, ERR_OK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_axi_lsu.md
# cpu_axi_lsu

Parametrised AXI4-Lite load/store unit. The CPU core hands it every data access that falls outside the program (BRAM) space. It supports byte, half, word and (at DATA_W=64) doubleword accesses with correct lane steering, strobes and sign/zero extension. It reports misalignment, bus errors and timeouts back to the decoder as a single-cycle response. It sits between the core datapath (reg_b / reg_c / register-file write-back) and the external m_axi port.

## Interface
- ADDR_W, 32: AXI and request address width.
- DATA_W, 32: bus and register width; legal values are 32 and 64.
- TIMEOUT, 255: cycles a bus phase may stall before abort; 0 disables the timeout.
- aclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core access request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64).
- req_unsigned  in  1  zero-extend loads (lbu/lhu/lwu).
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  2  error code: 0 = OK, 1 = misaligned, 2 = bus error, 3 = timeout.
- AXI4-Lite master signals (widths ADDR_W / DATA_W / DATA_W/8 as applicable):
  - m_axi_awaddr, m_axi_awvalid, m_axi_awready
  - m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready
  - m_axi_bresp[1:0], m_axi_bvalid, m_axi_bready
  - m_axi_araddr, m_axi_arvalid, m_axi_arready
  - m_axi_rdata, m_axi_rresp[1:0], m_axi_rvalid, m_axi_rready

## Operation
- **Reset values:** every valid/ready output 0 except req_ready (1). All addresses, data and strobes are 0. rsp_err is 0. State is IDLE and the timeout counter is 0.
- **States:** IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, DONE.
- **IDLE:** when req_valid & req_ready, latch the request.
  - Misaligned (addr mod 2^size ≠ 0) or illegal size (size=3 at DATA_W=32) → DONE with err 1. No bus activity.
  - Load → RD_ADDR. Store → WR_XFER.
- **Lane math:** off = addr[log2(DATA_W/8)-1:0]. Bus address = addr with the low off bits cleared.
  - wdata = req_wdata << 8·off.
  - wstrb = ((1<<2^size)−1) << off.
  - Load data = (rdata >> 8·off), truncated to 8·2^size bits, then sign- or zero-extended to DATA_W.
- **RD_ADDR:** arvalid high until arready → RD_DATA.
- **RD_DATA:** rready high until rvalid. rresp ≠ OKAY gives err 2 and data 0. Then → DONE.
- **WR_XFER:** awvalid and wvalid are raised together. Each drops independently on its own handshake; either may complete first, or both in the same cycle. Move to WR_RESP once both are done.
- **WR_RESP:** bready high until bvalid. bresp ≠ OKAY gives err 2. Then → DONE.
- **DONE:** rsp_valid=1 for exactly one cycle with rdata/err, then → IDLE unconditionally.
- **Timeout:** the counter clears on every state change and increments in RD_*/WR_* states. At TIMEOUT:
  - drop all valid/ready outputs;
  - → DONE with err 3.
  - The slave is then considered hung. Late responses are ignored because ready stays 0.
- **Reset mid-transaction:** back to IDLE on the next edge, all AXI valids low, no rsp_valid. Any transaction in flight is abandoned.
- **Idle outputs:** no AXI valid is ever asserted while in IDLE or DONE.

## Timing
- All outputs are registered; there are no combinational paths from AXI inputs to AXI outputs.
- Request accepted at edge N:
  - AR/AW/W valid from cycle N+1.
  - Zero-wait slave: read handshake AR at N+1 and R at N+2, rsp_valid at N+3, req_ready high again at N+4. Writes have identical timing (AW+W at N+1, B at N+2).
  - Misaligned: rsp_valid at N+1, no AXI activity.
- Each added slave wait cycle adds exactly one cycle of latency.
- Sustained throughput is one access per 4 cycles.
- rsp_rdata and rsp_err are valid only while rsp_valid is high. Between responses they hold their last value.

## Structure
- **Package `cpu_axi_pkg`:**
  - size_e (BYTE/HALF/WORD/DWORD);
  - lsu_err_e (OK/MISALIGN/BUSERR/TIMEOUT);
  - AXI_OKAY/SLVERR/DECERR constants;
  - lsu_state_e.
- **Sub-module `axi_lane_align`:** purely combinational. It computes wstrb, shifted wdata and extended load data from off/size/unsigned. It is instantiated once and reused for both directions.

## Test plan
- DATA_W=32, lb from 0x1000_0003 with rdata 0x80FF_0000 → araddr 0x1000_0000, rsp_rdata 0xFFFF_FF80, err 0; lbu → 0x0000_0080.
- sh 0xBEEF to 0x1000_0002 → awaddr 0x1000_0000, wdata 0xBEEF_0000, wstrb 0b1100, rsp at N+3.
- Write with W handshake 3 cycles before AW (awready delayed 3) → each valid drops on its own handshake, exactly one AW and one W beat, rsp_valid pulse of 1 cycle.
- lw at 0x1000_0002 → err 1 at N+1, no arvalid ever asserted; rresp=SLVERR on an aligned lw → err 2, rdata 0.
- TIMEOUT=8, arready held 0 → arvalid drops after 8 stall cycles, err 3; rst asserted during RD_DATA → IDLE next edge, rready 0, no rsp_valid.
- DATA_W=64, ld from 0x2000_0008 returning 0x1122_3344_5566_7788 → exact value; sd with size 3 at DATA_W=32 → err 1.
